// File: rtl/fetch_icache_unit.sv
// Fetch stage: PC register, direct-mapped instruction cache and a single-outstanding line-refill FSM.
// Optional hit/miss performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_icache_unit #(
    parameter int               VADDR_W   = 32,
    parameter int               INSTR_W   = 32,
    parameter int               LINE_W    = 128,
    parameter int               NUM_LINES = 4,
    parameter logic [VADDR_W-1:0] RESET_PC = 'h1000,
    localparam int              OFF_W     = $clog2(LINE_W / 8),
    localparam int              LA_W      = VADDR_W - OFF_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_hit,
    input  logic [VADDR_W-1:0] pc_branch,
    input  logic               mem_rdy,
    input  logic [LINE_W-1:0]  mem_line,
    output logic [VADDR_W-1:0] pc,
    output logic [INSTR_W-1:0] instr,
    output logic [VADDR_W-1:0] instr_pc,
    output logic               instr_valid,
    output logic               mem_req,
    output logic [LA_W-1:0]    mem_req_addr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_hits,
    output logic [31:0]        perf_misses,
`endif
    output logic               state_dbg
);
    localparam int WPL    = LINE_W / INSTR_W;
    localparam int STEP   = INSTR_W / 8;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = VADDR_W - IDX_W - OFF_W;
    localparam int SLOT_W = $clog2(STEP);
    localparam int WSEL_W = $clog2(WPL);

    typedef enum logic {RUN = 1'b0, MISS = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [VADDR_W-1:0]   pc_q, pc_d, instr_pc_q, instr_pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 mem_req_q, mem_req_d;
    logic [LA_W-1:0]      mem_req_addr_q, mem_req_addr_d;
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [LINE_W-1:0]    data_d [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;

    logic [IDX_W-1:0]     idx, r_idx;
    logic [TAG_W-1:0]     tag, r_tag;
    logic [WSEL_W-1:0]    word;
    logic                 hit;
    logic [INSTR_W-1:0]   hit_word;
    logic [VADDR_W-1:0]   br_target;
    logic                 hit_evt, miss_evt;

    assign idx       = pc_q[OFF_W +: IDX_W];
    assign tag       = pc_q[VADDR_W-1 -: TAG_W];
    assign word      = pc_q[OFF_W-1 : SLOT_W];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign hit_word  = data_q[idx][word*INSTR_W +: INSTR_W];
    // Refill target comes from the latched request, not the (possibly redirected) pc.
    assign r_idx     = mem_req_addr_q[IDX_W-1:0];
    assign r_tag     = mem_req_addr_q[LA_W-1:IDX_W];
    assign br_target = pc_branch & ~VADDR_W'(STEP - 1);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_pc_d     = instr_pc_q;
        instr_valid_d  = instr_valid_q;
        mem_req_d      = mem_req_q;
        mem_req_addr_d = mem_req_addr_q;
        data_d         = data_q;
        tag_d          = tag_q;
        valid_d        = valid_q;
        hit_evt        = 1'b0;
        miss_evt       = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_hit) begin
                    pc_d          = br_target;
                    instr_valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (hit) begin
                    instr_d       = hit_word;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + VADDR_W'(STEP);
                    hit_evt       = 1'b1;
                end else begin
                    instr_valid_d  = 1'b0;
                    mem_req_d      = 1'b1;
                    mem_req_addr_d = pc_q[VADDR_W-1:OFF_W];
                    state_d        = MISS;
                    miss_evt       = 1'b1;
                end
            end
            MISS: begin
                instr_valid_d = 1'b0;
                if (branch_hit) pc_d = br_target;
                if (mem_rdy) begin
                    data_d[r_idx]  = mem_line;
                    tag_d[r_idx]   = r_tag;
                    valid_d[r_idx] = 1'b1;
                    mem_req_d      = 1'b0;
                    state_d        = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            instr_valid_q  <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_req_addr_q <= '0;
            valid_q        <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_pc_q     <= instr_pc_d;
            instr_valid_q  <= instr_valid_d;
            mem_req_q      <= mem_req_d;
            mem_req_addr_q <= mem_req_addr_d;
            valid_q        <= valid_d;
            data_q         <= data_d;
            tag_q          <= tag_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_hits_q, perf_hits_d, perf_misses_q, perf_misses_d;

    always_comb begin
        perf_hits_d   = perf_hits_q;
        perf_misses_d = perf_misses_q;
        if (hit_evt && perf_hits_q != '1)     perf_hits_d   = perf_hits_q + 32'd1;
        if (miss_evt && perf_misses_q != '1)  perf_misses_d = perf_misses_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else begin
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`else
    logic perf_unused;
    assign perf_unused = hit_evt | miss_evt;
`endif

    assign pc           = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = instr_valid_q;
    assign mem_req      = mem_req_q;
    assign mem_req_addr = mem_req_addr_q;
    assign state_dbg    = (state_q == MISS);
endmodule

// File: tb/tb_fetch_icache_unit.sv
// Bench for fetch_icache_unit: directed scenarios plus random branch/stall/refill traffic
// checked against a line-address cache model and a hashed memory image.
module tb_fetch_icache_unit;
  logic         clk = 1'b0;
  logic         reset, stall, branch_hit, mem_rdy;
  logic [31:0]  pc_branch;
  logic [127:0] mem_line;
  logic [31:0]  pc, instr, instr_pc;
  logic         instr_valid, mem_req, state_dbg;
  logic [27:0]  mem_req_addr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  perf_hits, perf_misses;
`endif

  fetch_icache_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_hit(branch_hit),
    .pc_branch(pc_branch), .mem_rdy(mem_rdy), .mem_line(mem_line),
    .pc(pc), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .mem_req(mem_req), .mem_req_addr(mem_req_addr),
`ifdef FETCH_PERF_CNT_EN
    .perf_hits(perf_hits), .perf_misses(perf_misses),
`endif
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory image: explicit lines override a hashed default
  logic [127:0] mem_img [logic [27:0]];

  function automatic logic [31:0] word_hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [127:0] l;
    if (mem_img.exists(la)) return mem_img[la];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = word_hash({la, 4'b0} + 32'(k * 4));
    return l;
  endfunction

  // reference model: cache remembers which line address sits at each index
  logic [31:0]  m_pc, m_instr, m_ipc;
  logic         m_iv, m_req, m_miss;
  logic [27:0]  m_req_line;
  logic [27:0]  c_line [4];
  bit           c_valid [4];
  logic [31:0]  m_hits, m_misses;
  logic [63:0]  exp_q [$];

  function automatic void model_reset();
    m_pc = 32'h1000; m_instr = '0; m_ipc = '0; m_iv = 0; m_req = 0; m_miss = 0;
    m_req_line = '0; m_hits = '0; m_misses = '0;
    for (int i = 0; i < 4; i++) begin c_valid[i] = 0; c_line[i] = '0; end
    exp_q.delete();
  endfunction

  function automatic bit cached(input logic [31:0] a);
    return c_valid[a[5:4]] && (c_line[a[5:4]] == a[31:4]);
  endfunction

  function automatic void model_step(input logic br, input logic [31:0] tgt,
                                     input logic st, input logic rdy);
    logic [127:0] ln;
    if (!m_miss) begin
      if (br) begin
        m_pc = tgt & ~32'h3;
        m_iv = 0;
      end else if (st) begin
      end else if (cached(m_pc)) begin
        ln      = line_of(m_pc[31:4]);
        m_instr = ln[m_pc[3:2]*32 +: 32];
        m_ipc   = m_pc;
        m_iv    = 1;
        exp_q.push_back({m_pc, m_instr});
        m_pc    = m_pc + 32'd4;
        if (m_hits != 32'hFFFFFFFF) m_hits++;
      end else begin
        m_iv = 0; m_req = 1; m_req_line = m_pc[31:4]; m_miss = 1;
        if (m_misses != 32'hFFFFFFFF) m_misses++;
      end
    end else begin
      m_iv = 0;
      if (br) m_pc = tgt & ~32'h3;
      if (rdy) begin
        c_valid[m_req_line[1:0]] = 1;
        c_line[m_req_line[1:0]]  = m_req_line;
        m_req = 0; m_miss = 0;
      end
    end
  endfunction

  // scoreboard
  task automatic compare_all();
    logic [63:0] e;
    check("pc", pc, m_pc);
    check("instr_valid", instr_valid, m_iv);
    check("instr", instr, m_instr);
    check("instr_pc", instr_pc, m_ipc);
    check("mem_req", mem_req, m_req);
    check("mem_req_addr", mem_req_addr, m_req_line);
    check("state", state_dbg, m_miss);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fetch", {instr_pc, instr}, e);
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_hits", perf_hits, m_hits);
    check("perf_misses", perf_misses, m_misses);
`endif
  endtask

  // driver: apply inputs at negedge, advance model, compare at next negedge
  task automatic step(input logic br, input logic [31:0] tgt, input logic st, input logic rdy);
    branch_hit = br; pc_branch = tgt; stall = st; mem_rdy = rdy;
    mem_line = (rdy && m_miss) ? line_of(m_req_line) : {$urandom, $urandom, $urandom, $urandom};
    model_step(br, tgt, st, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1; stall = 0; branch_hit = 0; mem_rdy = 0; pc_branch = '0; mem_line = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h1000);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_req_addr", mem_req_addr, 28'h0);
    reset = 0;
    model_reset();
    compare_all();
  endtask

  function automatic logic [31:0] pick_target();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 32'h1000 + 32'($urandom_range(0, 255));
    if (r <= 7) return 32'h2000 + 32'($urandom_range(0, 127));
    if (r == 8) return 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    logic br, st, rdy;
    mem_img[28'h100] = 128'h44444444_33333333_22222222_11111111;
    do_reset();

    // first miss and refill, four words in order, next-line miss
    step(0, 0, 0, 0);
    check("t1_req", mem_req, 1'b1);
    check("t1_addr", mem_req_addr, 28'h100);
    step(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0);
      check("t2_instr", instr, 32'h11111111 * (k + 1));
      check("t2_instr_pc", instr_pc, 32'h1000 + 32'(4 * k));
    end
    step(0, 0, 0, 0);
    check("t2_next_miss", mem_req_addr, 28'h101);
    step(0, 0, 0, 1);

    // redirect while hitting line 0x100, then stall mid-line
    step(1, 32'h1004, 0, 0);
    step(0, 0, 0, 0);
    step(1, 32'h100B, 0, 0);
    check("t3_bubble", instr_valid, 1'b0);
    step(0, 0, 0, 0);
    check("t3_instr", instr, 32'h33333333);
    check("t3_instr_pc", instr_pc, 32'h1008);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 0);
      check("t5_pc", pc, 32'h100C);
      check("t5_instr", instr, 32'h33333333);
    end
    step(0, 0, 0, 0);
    check("t5_resume", instr, 32'h44444444);

    // conflict on index 0, then refetch of the evicted line
    step(1, 32'h1040, 0, 0);
    step(0, 0, 0, 0);
    check("t6_miss", mem_req_addr, 28'h104);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 32'h1000, 0, 0);
    step(0, 0, 0, 0);
    check("t6_refetch", mem_req_addr, 28'h100);
    step(0, 0, 0, 1);

    // branch during a refill: old line completes, new pc misses next
    step(1, 32'h1020, 0, 0);
    step(0, 0, 0, 0);
    step(1, 32'h2000, 0, 0);
    check("t4_addr_stable", mem_req_addr, 28'h102);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    check("t4_new_miss", mem_req_addr, 28'h200);
    step(0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      br  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 5) == 0);
      rdy = m_miss ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      step(br, pick_target(), st, rdy);
    end

    // reset in the middle of a refill; stray mem_rdy afterwards is ignored
    step(1, 32'h3000, 0, 0);
    step(0, 0, 0, 0);
    check("mid_refill_req", mem_req, 1'b1);
    do_reset();
    for (int n = 0; n < 40; n++) step(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
